// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial full subtractor with start/done handshake
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             borrow_out_q, borrow_out_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    // single full-subtractor cell operating on the current LSBs
    logic ai, bi, bin, d_bit, bout;
    assign ai    = a_sh_q[0];
    assign bi    = b_sh_q[0];
    assign bin   = borrow_q;
    assign d_bit = ai ^ bi ^ bin;
    assign bout  = (~ai & bi) | (~(ai ^ bi) & bin);

    // state register and datapath registers; reset abandons any operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            borrow_out_q <= 1'b0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            diff_q       <= diff_d;
            cnt_q        <= cnt_d;
            borrow_q     <= borrow_d;
            a_msb_q      <= a_msb_d;
            b_msb_q      <= b_msb_d;
            borrow_out_q <= borrow_out_d;
            ovf_q        <= ovf_d;
            done_q       <= done_d;
        end
    end

    // next-state logic: capture in IDLE, one bit per edge in SHIFT, pulse in DONE
    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        diff_d       = diff_q;
        cnt_d        = cnt_q;
        borrow_d     = borrow_q;
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        borrow_out_d = borrow_out_q;
        ovf_d        = ovf_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                diff_d   = {d_bit, diff_q[WIDTH-1:1]};
                borrow_d = bout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d      = DONE;
                    borrow_out_d = bout;
                    // the last d_bit is the result sign bit
                    ovf_d        = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
                    done_d       = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign ovf        = ovf_q;

endmodule
